// File: rtl/spm_boot_loader.sv
// Boot loader for the RISC_SPM memory: flushes every word, streams a
// program in over valid/ready, then releases the CPU from reset.
module spm_boot_loader #(
  parameter int unsigned           word_size  = 8,
  parameter int unsigned           addr_size  = 8,
  parameter logic [word_size-1:0]  fill_value = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [addr_size-1:0] load_addr,
  input  logic [word_size-1:0] load_data,
  input  logic                 load_done,
  input  logic                 reload,
  output logic                 mem_we,
  output logic [addr_size-1:0] mem_addr,
  output logic [word_size-1:0] mem_wdata,
  output logic                 cpu_rst,
  output logic                 busy,
  output logic [addr_size:0]   words_loaded
);

  localparam logic [addr_size:0] LAST =
    {1'b0, {addr_size{1'b1}}};
  localparam logic [addr_size:0] FULL =
    {1'b1, {addr_size{1'b0}}};

  typedef enum logic [1:0] {
    FLUSH,
    LOAD,
    RUN
  } state_e;

  state_e               state_q;
  logic [addr_size:0]   cnt_q;
  logic [addr_size:0]   cnt_d;
  logic [addr_size:0]   words_q;
  logic [addr_size:0]   words_d;
  logic                 we_q;
  logic [addr_size-1:0] addr_q;
  logic [word_size-1:0] wdata_q;
  logic                 ready_q;
  logic                 cpu_rst_q;
  logic                 busy_q;
  logic                 accept;

  // Handshake uses the registered ready, so no input reaches an output.
  assign accept  = load_valid && ready_q;
  assign cnt_d   = cnt_q + 1'b1;
  assign words_d = (words_q == FULL) ? words_q
                                     : words_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FLUSH;
      cnt_q     <= '0;
      words_q   <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= fill_value;
      ready_q   <= 1'b0;
      cpu_rst_q <= 1'b0;
      busy_q    <= 1'b1;
    end else if (reload) begin
      state_q   <= FLUSH;
      cnt_q     <= '0;
      words_q   <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= fill_value;
      ready_q   <= 1'b0;
      cpu_rst_q <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      unique case (state_q)
        FLUSH: begin
          we_q    <= 1'b1;
          addr_q  <= cnt_q[addr_size-1:0];
          wdata_q <= fill_value;
          cnt_q   <= cnt_d;
          if (cnt_q == LAST) state_q <= LOAD;
        end
        LOAD: begin
          ready_q <= 1'b1;
          we_q    <= accept;
          if (accept) begin
            addr_q  <= load_addr;
            wdata_q <= load_data;
            words_q <= words_d;
          end
          if (load_done) begin
            state_q   <= RUN;
            ready_q   <= 1'b0;
            cpu_rst_q <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        RUN: begin
          we_q      <= 1'b0;
          ready_q   <= 1'b0;
          cpu_rst_q <= 1'b1;
          busy_q    <= 1'b0;
        end
        default: state_q <= FLUSH;
      endcase
    end
  end

  assign load_ready   = ready_q;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign cpu_rst      = cpu_rst_q;
  assign busy         = busy_q;
  assign words_loaded = words_q;

endmodule
